// File: rtl/mux_pkg.sv
// Shared constants and helpers for the stream multiplexers and arbiters.
package mux_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Index width for n channels; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_grant.sv
// Combinational grant picker: fixed priority (lowest index) or round-robin
// search upward from rr_ptr, wrapping at NUM_INPUTS.
module arb_grant
    import mux_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int SEL_W      = sel_width(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [SEL_W-1:0]      rr_ptr,
    input  logic                  mode,
    output logic [SEL_W-1:0]      grant,
    output logic                  has_grant
);

    // First requester found wins; the search origin is 0 or rr_ptr.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        has_grant = 1'b0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            idx = (int'(mode) == ARB_RR) ? int'(rr_ptr) + k : k;
            if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
            if (!has_grant && req[idx]) begin
                grant     = SEL_W'(idx);
                has_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_stream_mux.sv
// N-to-1 valid/ready stream mux with internal arbitration, packet locking
// and a single registered output stage.
module arb_stream_mux
    import mux_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  NUM_INPUTS = 4,
    parameter int  ARB_MODE   = 1,
    localparam int SEL_W      = sel_width(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DATA_WIDTH*NUM_INPUTS-1:0] in_data_flat,
    input  logic [NUM_INPUTS-1:0]            in_last_flat,
    input  logic [NUM_INPUTS-1:0]            in_valid_flat,
    output logic [NUM_INPUTS-1:0]            in_ready_flat,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_last,
    output logic [SEL_W-1:0]                 out_sel,
    output logic                             out_valid,
    input  logic                             out_ready
);

    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic [SEL_W-1:0]      out_sel_q,  out_sel_d;
    logic                  out_valid_q, out_valid_d;
    logic [SEL_W-1:0]      rr_ptr_q,   rr_ptr_d;
    logic                  locked_q,   locked_d;
    logic [SEL_W-1:0]      lock_idx_q, lock_idx_d;

    logic [SEL_W-1:0]      arb_idx;
    logic                  arb_has;
    logic [SEL_W-1:0]      grant;
    logic                  has_grant;
    logic                  can_load;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  xfer;

    arb_grant #(
        .NUM_INPUTS (NUM_INPUTS),
        .SEL_W      (SEL_W)
    ) u_arb_grant (
        .req       (in_valid_flat),
        .rr_ptr    (rr_ptr_q),
        .mode      (ARB_MODE == ARB_RR),
        .grant     (arb_idx),
        .has_grant (arb_has)
    );

    // Grant selection, channel mux and per-channel ready; an open packet
    // pins the grant to its channel even while that channel is idle.
    always_comb begin
        can_load      = !out_valid_q || out_ready;
        grant         = locked_q ? lock_idx_q : arb_idx;
        has_grant     = locked_q || arb_has;
        sel_valid     = 1'b0;
        sel_last      = 1'b0;
        sel_data      = '0;
        in_ready_flat = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant == SEL_W'(i)) begin
                sel_valid = in_valid_flat[i];
                sel_last  = in_last_flat[i];
                sel_data  = in_data_flat[i*DATA_WIDTH +: DATA_WIDTH];
            end
            in_ready_flat[i] = rst_n && can_load && has_grant && (grant == SEL_W'(i));
        end
        xfer = rst_n && can_load && has_grant && sel_valid;
    end

    // Next state for the output register, packet lock and round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        locked_d    = locked_q;
        lock_idx_d  = lock_idx_q;
        if (xfer) begin
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_sel_d   = grant;
            out_valid_d = 1'b1;
            if (!sel_last) begin
                locked_d   = 1'b1;
                lock_idx_d = grant;
            end else begin
                locked_d = 1'b0;
                if (ARB_MODE == ARB_RR) begin
                    rr_ptr_d = (int'(grant) == NUM_INPUTS - 1) ? '0 : grant + SEL_W'(1);
                end
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
            locked_q    <= 1'b0;
            lock_idx_q  <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            locked_q    <= locked_d;
            lock_idx_q  <= lock_idx_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_stream_mux.sv
// Directed bench: fixed-priority, round-robin (N=4) and round-robin (N=3)
// instances share one stimulus bus.
module tb_arb_stream_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ordy;
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic [31:0] dat;

    logic [3:0]  rdy_fp, rdy_rr;
    logic [2:0]  rdy_r3;
    logic [7:0]  od_fp, od_rr, od_r3;
    logic        ol_fp, ol_rr, ol_r3;
    logic [1:0]  os_fp, os_rr, os_r3;
    logic        ov_fp, ov_rr, ov_r3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arb_stream_mux #(.DATA_WIDTH(8), .NUM_INPUTS(4), .ARB_MODE(0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .in_data_flat(dat), .in_last_flat(lst),
        .in_valid_flat(vld), .in_ready_flat(rdy_fp), .out_data(od_fp),
        .out_last(ol_fp), .out_sel(os_fp), .out_valid(ov_fp), .out_ready(ordy));

    arb_stream_mux #(.DATA_WIDTH(8), .NUM_INPUTS(4), .ARB_MODE(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .in_data_flat(dat), .in_last_flat(lst),
        .in_valid_flat(vld), .in_ready_flat(rdy_rr), .out_data(od_rr),
        .out_last(ol_rr), .out_sel(os_rr), .out_valid(ov_rr), .out_ready(ordy));

    arb_stream_mux #(.DATA_WIDTH(8), .NUM_INPUTS(3), .ARB_MODE(1)) dut_r3 (
        .clk(clk), .rst_n(rst_n), .in_data_flat(dat[23:0]), .in_last_flat(lst[2:0]),
        .in_valid_flat(vld[2:0]), .in_ready_flat(rdy_r3), .out_data(od_r3),
        .out_last(ol_r3), .out_sel(os_r3), .out_valid(ov_r3), .out_ready(ordy));

    typedef struct {
        logic        rst;
        logic        ordy;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [31:0] dat;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [7:0]  e_od;
        logic        e_ol;
        logic [1:0]  e_os;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic o, input logic [3:0] v,
                                input logic [3:0] l, input logic [31:0] d,
                                input logic [3:0] er, input logic eov, input logic [7:0] eod,
                                input logic eol, input logic [1:0] eos);
        vec_t t;
        t.rst = r; t.ordy = o; t.vld = v; t.lst = l; t.dat = d;
        t.e_rdy = er; t.e_ov = eov; t.e_od = eod; t.e_ol = eol; t.e_os = eos;
        return t;
    endfunction

    int exp_rr[6] = '{0, 1, 2, 3, 0, 1};
    int exp_r3[6] = '{0, 1, 2, 0, 1, 2};
    int exp_lk[4] = '{0, 0, 0, 1};
    logic [31:0] dsel;

    initial begin
        rst_n = 1'b0; ordy = 1'b1; vld = '0; lst = '0; dat = '0;

        //           rst ordy vld      lst      data          e_rdy    ov  od     ol  os
        // reset held with all channels valid, then first beat
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1111, 32'h33221101, 4'b0000, 0, 8'h00, 0, 2'd0));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1111, 32'h33221101, 4'b0000, 0, 8'h00, 0, 2'd0));
        tbl.push_back(mk(1, 1, 4'b1111, 4'b1111, 32'h33221101, 4'b0001, 1, 8'h01, 1, 2'd0));
        // fixed priority: ch1 beats ch3, then ch3 alone
        tbl.push_back(mk(1, 1, 4'b1010, 4'b1111, 32'h33221101, 4'b0010, 1, 8'h11, 1, 2'd1));
        tbl.push_back(mk(1, 1, 4'b1010, 4'b1111, 32'h33221101, 4'b0010, 1, 8'h11, 1, 2'd1));
        tbl.push_back(mk(1, 1, 4'b1000, 4'b1111, 32'h33221101, 4'b1000, 1, 8'h33, 1, 2'd3));
        // backpressure: 0x5A held three cycles, next beat loads with no bubble
        tbl.push_back(mk(1, 1, 4'b0010, 4'b1111, 32'h33225A01, 4'b0010, 1, 8'h5A, 1, 2'd1));
        tbl.push_back(mk(1, 0, 4'b1010, 4'b1111, 32'h33226B01, 4'b0000, 1, 8'h5A, 1, 2'd1));
        tbl.push_back(mk(1, 0, 4'b1010, 4'b1111, 32'h33226B01, 4'b0000, 1, 8'h5A, 1, 2'd1));
        tbl.push_back(mk(1, 0, 4'b1010, 4'b1111, 32'h33226B01, 4'b0000, 1, 8'h5A, 1, 2'd1));
        tbl.push_back(mk(1, 1, 4'b1010, 4'b1111, 32'h33226B01, 4'b0010, 1, 8'h6B, 1, 2'd1));
        // packet lock on ch2 with a two-cycle gap while ch0 keeps requesting
        tbl.push_back(mk(1, 1, 4'b0100, 4'b0001, 32'h33A01101, 4'b0100, 1, 8'hA0, 0, 2'd2));
        tbl.push_back(mk(1, 1, 4'b0101, 4'b0001, 32'h33A11101, 4'b0100, 1, 8'hA1, 0, 2'd2));
        tbl.push_back(mk(1, 1, 4'b0001, 4'b0001, 32'h33A11101, 4'b0100, 0, 8'hA1, 0, 2'd2));
        tbl.push_back(mk(1, 1, 4'b0001, 4'b0001, 32'h33A11101, 4'b0100, 0, 8'hA1, 0, 2'd2));
        tbl.push_back(mk(1, 1, 4'b0101, 4'b0101, 32'h33A21101, 4'b0100, 1, 8'hA2, 1, 2'd2));
        tbl.push_back(mk(1, 1, 4'b0001, 4'b0001, 32'h33A21101, 4'b0001, 1, 8'h01, 1, 2'd0));
        // reset in the middle of a ch2 packet
        tbl.push_back(mk(1, 1, 4'b0100, 4'b0001, 32'h33A01101, 4'b0100, 1, 8'hA0, 0, 2'd2));
        tbl.push_back(mk(0, 1, 4'b0101, 4'b0001, 32'h33A01101, 4'b0000, 0, 8'h00, 0, 2'd0));
        tbl.push_back(mk(1, 1, 4'b0101, 4'b0001, 32'h33A01101, 4'b0001, 1, 8'h01, 1, 2'd0));

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst; ordy = tbl[i].ordy; vld = tbl[i].vld;
            lst = tbl[i].lst; dat = tbl[i].dat;
            @(negedge clk);
            chk($sformatf("r%0d_ready", i), 32'(rdy_fp), 32'(tbl[i].e_rdy));
            @(posedge clk); #1;
            chk($sformatf("r%0d_valid", i), 32'(ov_fp), 32'(tbl[i].e_ov));
            chk($sformatf("r%0d_data", i),  32'(od_fp), 32'(tbl[i].e_od));
            chk($sformatf("r%0d_last", i),  32'(ol_fp), 32'(tbl[i].e_ol));
            chk($sformatf("r%0d_sel", i),   32'(os_fp), 32'(tbl[i].e_os));
        end

        // round-robin rotation, N=4 and N=3
        rst_n = 1'b0; ordy = 1'b1; vld = 4'b1111; lst = 4'b1111; dat = 32'h33221101;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rr4_sel%0d", k), 32'(os_rr), 32'(exp_rr[k]));
            chk($sformatf("rr4_valid%0d", k), 32'(ov_rr), 32'd1);
            chk($sformatf("rr3_sel%0d", k), 32'(os_r3), 32'(exp_r3[k]));
            dsel = dat >> (8 * exp_r3[k]);
            chk($sformatf("rr3_data%0d", k), 32'(od_r3), 32'(dsel[7:0]));
        end

        // round-robin: a multi-beat packet on ch0 holds the grant and the pointer
        rst_n = 1'b0; lst = 4'b1110;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lst = (k < 2) ? 4'b1110 : 4'b1111;
            @(negedge clk);
            if (k > 0) chk($sformatf("rrlock_ready%0d", k), 32'(rdy_rr), 32'(4'b0001 << exp_lk[k]));
            @(posedge clk); #1;
            chk($sformatf("rrlock_sel%0d", k), 32'(os_rr), 32'(exp_lk[k]));
            chk($sformatf("rrlock_last%0d", k), 32'(ol_rr), (k < 2) ? 32'd0 : 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
